terminal_reader: RTL and testbench

TERMINAL_READER -- requirements
Module: terminal_reader

---
 rtl/terminal_reader.sv | 176 +++++++++++++++++
 tb/tb_terminal_reader.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/terminal_reader.sv
// terminal_reader: walks the text grid row by row and streams each line's ASCII over valid/ready,
// closing every line with a newline. Build macro TERMINAL_READER_SPACE_SKIP_EN drops space bytes.
module terminal_reader #(
  parameter  int SCREEN_WIDTH  = 76,
  parameter  int SCREEN_HEIGHT = 44,
  parameter  int TEXT_ROWS     = 42,
  parameter  int READ_LATENCY  = 2,
  localparam int AW            = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
  localparam int RW            = $clog2(SCREEN_HEIGHT)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_n_in,
  input  logic          start_in,
  output logic [AW-1:0] tg_addr_out,
  input  logic [7:0]    tg_data_in,
  output logic [7:0]    char_out,
  output logic          char_valid_out,
  input  logic          char_ready_in,
  output logic [RW-1:0] row_out,
  output logic          busy_out,
  output logic          done_out
);
  localparam int CW = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1;
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [CW-1:0] LAST_COL  = CW'(SCREEN_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(TEXT_ROWS - 1);
  localparam logic [LW-1:0] LAST_WAIT = LW'(READ_LATENCY - 1);
  localparam logic [7:0]    ASCII_LF  = 8'd10;
`ifdef TERMINAL_READER_SPACE_SKIP_EN
  localparam logic [7:0]    ASCII_SP  = 8'd32;
`endif

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, EOL, DONE} state_t;

  state_t        state_r, state_s;
  logic [RW-1:0] row_r, row_s, row_inc_s;
  logic [CW-1:0] col_r, col_s, col_inc_s;
  logic [LW-1:0] wait_cnt_r, wait_cnt_s;
  logic [AW-1:0] tg_addr_s;
  logic [7:0]    char_s;
  logic          char_valid_s, busy_s, done_s;
  logic          transfer_s, row_last_s, col_last_s;

  // Widen before multiplying so the product never truncates to the row width.
  function automatic logic [AW-1:0] grid_addr(input logic [RW-1:0] row, input logic [CW-1:0] col);
    return AW'(row) * AW'(SCREEN_WIDTH) + AW'(col);
  endfunction

  assign row_out = row_r;

  // Next-state and next-output decode for the scan FSM.
  always_comb begin
    state_s      = state_r;
    row_s        = row_r;
    col_s        = col_r;
    wait_cnt_s   = wait_cnt_r;
    tg_addr_s    = tg_addr_out;
    char_s       = char_out;
    char_valid_s = 1'b0;
    busy_s       = busy_out;
    done_s       = 1'b0;
    transfer_s   = char_valid_out & char_ready_in;
    row_inc_s    = row_r + 1'b1;
    col_inc_s    = col_r + 1'b1;
    row_last_s   = (row_r == LAST_ROW);
    col_last_s   = (col_r == LAST_COL);

    case (state_r)
      IDLE: begin
        if (start_in) begin
          row_s     = '0;
          col_s     = '0;
          tg_addr_s = '0;
          busy_s    = 1'b1;
          state_s   = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        wait_cnt_s = '0;
        state_s    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_r == LAST_WAIT) begin
`ifdef TERMINAL_READER_SPACE_SKIP_EN
          if (tg_data_in != ASCII_SP) begin
            char_s       = tg_data_in;
            char_valid_s = 1'b1;
            state_s      = PRESENT;
          end else if (col_last_s) begin
            char_s       = ASCII_LF;
            char_valid_s = 1'b1;
            state_s      = EOL;
          end else begin
            col_s     = col_inc_s;
            tg_addr_s = grid_addr(row_r, col_inc_s);
            state_s   = ISSUE;
          end
`else
          char_s       = tg_data_in;
          char_valid_s = 1'b1;
          state_s      = PRESENT;
`endif
        end else begin
          wait_cnt_s = wait_cnt_r + 1'b1;
        end
      end
      PRESENT: begin
        if (!transfer_s) begin
          char_valid_s = 1'b1;
        end else if (char_out == ASCII_LF) begin
          col_s     = '0;
          row_s     = row_last_s ? row_r : row_inc_s;
          tg_addr_s = row_last_s ? tg_addr_out : grid_addr(row_inc_s, '0);
          busy_s    = !row_last_s;
          done_s    = row_last_s;
          state_s   = row_last_s ? DONE : ISSUE;
        end else if (col_last_s) begin
          char_s       = ASCII_LF;
          char_valid_s = 1'b1;
          state_s      = EOL;
        end else begin
          col_s     = col_inc_s;
          tg_addr_s = grid_addr(row_r, col_inc_s);
          state_s   = ISSUE;
        end
      end
      EOL: begin
        if (transfer_s) begin
          col_s     = '0;
          row_s     = row_last_s ? row_r : row_inc_s;
          tg_addr_s = row_last_s ? tg_addr_out : grid_addr(row_inc_s, '0);
          busy_s    = !row_last_s;
          done_s    = row_last_s;
          state_s   = row_last_s ? DONE : ISSUE;
        end else begin
          char_valid_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons the scan and ignores any read still in flight.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      state_r        <= IDLE;
      row_r          <= '0;
      col_r          <= '0;
      wait_cnt_r     <= '0;
      tg_addr_out    <= '0;
      char_out       <= 8'd0;
      char_valid_out <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
    end else begin
      state_r        <= state_s;
      row_r          <= row_s;
      col_r          <= col_s;
      wait_cnt_r     <= wait_cnt_s;
      tg_addr_out    <= tg_addr_s;
      char_out       <= char_s;
      char_valid_out <= char_valid_s;
      busy_out       <= busy_s;
      done_out       <= done_s;
    end
  end

endmodule

// File: tb/tb_terminal_reader.sv
// tb_terminal_reader: table vectors, hand sequences and random grids for terminal_reader,
// checked against a line-oriented model of the expected character stream.
module tb_terminal_reader;
  localparam int SCREEN_WIDTH  = 76;
  localparam int SCREEN_HEIGHT = 44;
  localparam int TEXT_ROWS     = 42;
  localparam int READ_LATENCY  = 2;
  localparam int AW            = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam int RW            = $clog2(SCREEN_HEIGHT);
  localparam int CELLS         = SCREEN_WIDTH * SCREEN_HEIGHT;

  logic          pixel_clk_in;
  logic          rst_n_in;
  logic          start_in;
  logic [AW-1:0] tg_addr_out;
  logic [7:0]    tg_data_in;
  logic [7:0]    char_out;
  logic          char_valid_out;
  logic          char_ready_in;
  logic [RW-1:0] row_out;
  logic          busy_out;
  logic          done_out;

  terminal_reader #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .TEXT_ROWS    (TEXT_ROWS),
    .READ_LATENCY (READ_LATENCY)
  ) dut (
    .pixel_clk_in  (pixel_clk_in),
    .rst_n_in      (rst_n_in),
    .start_in      (start_in),
    .tg_addr_out   (tg_addr_out),
    .tg_data_in    (tg_data_in),
    .char_out      (char_out),
    .char_valid_out(char_valid_out),
    .char_ready_in (char_ready_in),
    .row_out       (row_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  initial begin
    pixel_clk_in = 1'b0;
    forever #5 pixel_clk_in = ~pixel_clk_in;
  end

  // Text-grid BRAM: READ_LATENCY register stages between address and data.
  logic [7:0] mem [CELLS];
  logic [7:0] rd_pipe [READ_LATENCY];
  always @(posedge pixel_clk_in) begin
    rd_pipe[0] <= mem[tg_addr_out];
    for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign tg_data_in = rd_pipe[READ_LATENCY-1];

  int cyc = 0;
  always @(posedge pixel_clk_in) cyc <= cyc + 1;

  logic [7:0]    got_char_q[$];
  logic [RW-1:0] got_row_q[$];
  logic [7:0]    exp_char_q[$];
  logic [RW-1:0] exp_row_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int last_xfer_cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  // Transfers and done pulses are sampled mid-cycle, away from the active edge.
  always @(negedge pixel_clk_in) begin
    if (char_valid_out === 1'b1 && char_ready_in === 1'b1) begin
      got_char_q.push_back(char_out);
      got_row_q.push_back(row_out);
      last_xfer_cyc = cyc;
    end
    if (done_out === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk_in);
    #1;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic clear_capture();
    got_char_q.delete();
    got_row_q.delete();
    done_cnt      = 0;
    done_cyc      = 0;
    last_xfer_cyc = 0;
  endtask

  task automatic fill_all(input logic [7:0] b);
    for (int i = 0; i < CELLS; i++) mem[i] = b;
  endtask

  task automatic put(input int r, input int c, input logic [7:0] b);
    mem[r*SCREEN_WIDTH + c] = b;
  endtask

  task automatic fill_random();
    for (int r = 0; r < SCREEN_HEIGHT; r++) begin
      int len;
      len = ($urandom_range(7, 0) == 0) ? SCREEN_WIDTH : int'($urandom_range(12, 0));
      for (int c = 0; c < SCREEN_WIDTH; c++) begin
        logic [7:0] b;
        b = 8'($urandom_range(126, 32));
        if ($urandom_range(3, 0) == 0) b = 8'd32;
        if (c == len) b = 8'd10;
        put(r, c, b);
      end
    end
  endtask

  // Model: each text row yields its bytes up to and including the first newline,
  // or all SCREEN_WIDTH bytes plus a synthetic newline when none is found.
  task automatic build_expected();
    exp_char_q.delete();
    exp_row_q.delete();
    for (int r = 0; r < TEXT_ROWS; r++) begin
      for (int c = 0; c < SCREEN_WIDTH; c++) begin
        logic [7:0] b;
        b = mem[r*SCREEN_WIDTH + c];
        if (b == 8'd10) begin
          exp_char_q.push_back(8'd10);
          exp_row_q.push_back(RW'(r));
          break;
        end
`ifdef TERMINAL_READER_SPACE_SKIP_EN
        if (b != 8'd32) begin
          exp_char_q.push_back(b);
          exp_row_q.push_back(RW'(r));
        end
`else
        exp_char_q.push_back(b);
        exp_row_q.push_back(RW'(r));
`endif
        if (c == SCREEN_WIDTH - 1) begin
          exp_char_q.push_back(8'd10);
          exp_row_q.push_back(RW'(r));
        end
      end
    end
  endtask

  task automatic wait_done(input bit rand_ready, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40000 && !seen; k++) begin
      char_ready_in = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
      tick();
      if (done_out === 1'b1) seen = 1'b1;
    end
    char_ready_in = 1'b1;
    repeat (4) tick();
    check({name, " done within budget"}, 32'(seen), 32'd1);
    check({name, " busy cleared"}, 32'(busy_out), 32'd0);
  endtask

  task automatic check_stream(input string name);
    int n_bad;
    int n;
    n_bad = 0;
    build_expected();
    check({name, " stream length"}, got_char_q.size(), exp_char_q.size());
    n = (got_char_q.size() < exp_char_q.size()) ? got_char_q.size() : exp_char_q.size();
    for (int i = 0; i < n; i++) begin
      if (got_char_q[i] !== exp_char_q[i] || got_row_q[i] !== exp_row_q[i]) n_bad++;
    end
    check({name, " wrong char/row entries"}, n_bad, 32'd0);
    check({name, " done pulses"}, done_cnt, 32'd1);
    check({name, " done delay after last transfer"}, done_cyc - last_xfer_cyc, 32'd1);
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         exp_len;
    logic [7:0] exp_first;
    logic [7:0] exp_second;
  } vec_t;

  vec_t vecs [4];

  initial begin
    // Row 0 = b0, b1, newline; every other row is a bare newline.
    vecs[0] = '{8'h41, 8'h42, 44, 8'h41, 8'h42};
    vecs[1] = '{8'h0A, 8'h42, 42, 8'h0A, 8'h0A};
    vecs[2] = '{8'h7E, 8'h0A, 43, 8'h7E, 8'h0A};
    vecs[3] = '{8'h00, 8'hFF, 44, 8'h00, 8'hFF};

    fill_all(8'd10);
    rst_n_in      = 1'b0;
    start_in      = 1'b0;
    char_ready_in = 1'b1;
    tick();
    tick();
    rst_n_in = 1'b1;
    check("reset tg_addr_out", 32'(tg_addr_out), 32'd0);
    check("reset char_out", 32'(char_out), 32'd0);
    check("reset char_valid_out", 32'(char_valid_out), 32'd0);
    check("reset row_out", 32'(row_out), 32'd0);
    check("reset busy_out", 32'(busy_out), 32'd0);
    check("reset done_out", 32'(done_out), 32'd0);

    // Latency and full scan: row0 "ab\n", everything else spaces.
    fill_all(8'd32);
    put(0, 0, 8'h61);
    put(0, 1, 8'h62);
    put(0, 2, 8'h0A);
    clear_capture();
    pulse_start();
    check("latency addr cycle1", 32'(tg_addr_out), 32'd0);
    check("latency busy cycle1", 32'(busy_out), 32'd1);
    check("latency valid cycle1", 32'(char_valid_out), 32'd0);
    tick();
    check("latency valid cycle2", 32'(char_valid_out), 32'd0);
    tick();
    check("latency valid cycle3", 32'(char_valid_out), 32'd0);
    tick();
    check("latency valid cycle4", 32'(char_valid_out), 32'd1);
    check("latency char cycle4", 32'(char_out), 32'h61);
    tick();
    check("second read addr", 32'(tg_addr_out), 32'd1);
    wait_done(1'b0, "full scan");
    check_stream("full scan");
`ifdef TERMINAL_READER_SPACE_SKIP_EN
    check("full scan byte count", got_char_q.size(), 32'd44);
`else
    check("full scan byte count", got_char_q.size(), 32'd3160);
`endif

    // Backpressure, then reset while a byte is being presented.
    fill_all(8'h2E);
    for (int r = 1; r < SCREEN_HEIGHT; r++) put(r, 0, 8'h0A);
    for (int c = 0; c < 12; c++) put(0, c, 8'(8'h61 + c));
    put(0, 12, 8'h0A);
    clear_capture();
    char_ready_in = 1'b0;
    pulse_start();
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      check("stall valid held", 32'(char_valid_out), 32'd1);
      check("stall char held", 32'(char_out), 32'h61);
      check("stall addr held", 32'(tg_addr_out), 32'd0);
      tick();
    end
    check("stall no transfers", got_char_q.size(), 32'd0);
    char_ready_in = 1'b1;
    for (int k = 0; k < 500 && got_char_q.size() < 10; k++) tick();
    char_ready_in = 1'b0;
    for (int k = 0; k < 20 && char_valid_out !== 1'b1; k++) tick();
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    check("mid reset valid", 32'(char_valid_out), 32'd0);
    check("mid reset busy", 32'(busy_out), 32'd0);
    check("mid reset done", 32'(done_out), 32'd0);
    char_ready_in = 1'b1;
    repeat (8) tick();
    check("mid reset transfers", got_char_q.size(), 32'd10);
    check("mid reset no done", done_cnt, 32'd0);
    clear_capture();
    pulse_start();
    check("restart addr", 32'(tg_addr_out), 32'd0);
    wait_done(1'b0, "restart");
    check_stream("restart");

    // A second start while busy must not disturb the scan.
    clear_capture();
    pulse_start();
    repeat (6) tick();
    pulse_start();
    wait_done(1'b0, "ignored start");
    check_stream("ignored start");

    // Full row of 'x' with no newline: synthetic newline, then row 1 at address 76.
    fill_all(8'h0A);
    for (int c = 0; c < SCREEN_WIDTH; c++) put(0, c, 8'h78);
    clear_capture();
    pulse_start();
    for (int k = 0; k < 1000 && got_char_q.size() < 77; k++) tick();
    check("full row next addr", 32'(tg_addr_out), 32'd76);
    wait_done(1'b0, "full row");
    check("full row last x", 32'(got_char_q[75]), 32'h78);
    check("full row synthetic newline", 32'(got_char_q[76]), 32'h0A);
    check("full row newline row", 32'(got_row_q[76]), 32'd0);
    check_stream("full row");

    // Table vectors.
    for (int v = 0; v < 4; v++) begin
      fill_all(8'h0A);
      put(0, 0, vecs[v].b0);
      put(0, 1, vecs[v].b1);
      put(0, 2, 8'h0A);
      clear_capture();
      pulse_start();
      wait_done(1'b0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d length", v), got_char_q.size(), vecs[v].exp_len);
      check($sformatf("vec%0d first", v), 32'(got_char_q[0]), 32'(vecs[v].exp_first));
      check($sformatf("vec%0d second", v), 32'(got_char_q[1]), 32'(vecs[v].exp_second));
      check($sformatf("vec%0d done pulses", v), done_cnt, 32'd1);
    end

    // Random grids with random consumer backpressure.
    for (int s = 0; s < 3; s++) begin
      fill_random();
      clear_capture();
      pulse_start();
      wait_done(1'b1, $sformatf("random%0d", s));
      check_stream($sformatf("random%0d", s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
